multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing controller for the multicycle ARM-subset datapath. Each instruction passes through FETCH, DECODE and execute/memory/writeback states, with one state per clock and stalls on memory. The block owns the NZCV flag register and evaluates the condition field to gate architectural writes. It sits beside the datapath, takes the instruction fields from the datapath's IR plus the ALU flags, and drives every datapath and memory enable/select.

## Interface
- No parameters.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `Cond` in 4: IR[31:28].
- `Op` in 2: IR[27:26].
- `Funct` in 6: IR[25:20].
- `Rd` in 4: IR[15:12].
- `ALUFlags` in 4: live ALU {N,Z,C,V}.
- `mem_ready` in 1: memory completes the access this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select, 0=PC, 1=ALUOut.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: IR enable.
- `ResultSrc` out 2: 00=ALUOut, 01=Data, 10=ALU result.
- `ALUSrcA` out 1: 0=A register, 1=PC.
- `ALUSrcB` out 2: 00=WriteData, 01=ImmExt, 10=constant 4.
- `ALUControl` out 3: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV.
- `ImmSrc` out 2: 00 imm8, 01 imm12, 10 imm24 branch.
- `RegWrite` out 1: register file write enable.
- `RegSrc` out 2: bit1 selects Rd on RA2 (STR), bit0 selects R15 on RA1 (branch).
- `flags_q` out 4: current NZCV, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Go to DECODE when mem_ready, else hold.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD (PC+8 precompute). Next state:
  - Op=01 → MEMADR.
  - Op=00 with Funct[5]=1 → EXEC_I.
  - Op=00 with Funct[5]=0 → EXEC_R.
  - Op=10 → BRANCH.
  - Op=11 → FETCH (no-op).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ADD. Funct[0]=1 → MEMRD, else MEMWR.
- MEMRD: AdrSrc=1. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. Go to FETCH.
- MEMWR: AdrSrc=1, RegSrc=10, MemWrite=CondEx. Hold until mem_ready, then FETCH. MemWrite stays asserted through every stalled cycle.
- EXEC_R / EXEC_I:
  - ALUSrcA=0; ALUSrcB=00 (R) or 01 with ImmSrc=00 (I).
  - ALUControl from Funct[4:1]: 0010 SUB, 1010 CMP→SUB, 0000 AND, 1100 ORR, 1101 MOV, others ADD.
  - Flag update when Funct[0]=1 and CondEx:
    - N,Z always load.
    - C,V load only for ADD/SUB/CMP.
    - Flags latch at the end of this state.
  - Next ALUWB, except CMP → FETCH.
- ALUWB: ResultSrc=00, RegWrite=CondEx. If Rd=15 and CondEx, PCWrite=1 as well. Go to FETCH.
- BRANCH:
  - ALUSrcA=0, RegSrc=01, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10.
  - PCWrite=CondEx. Go to FETCH.
- CondEx is combinational from Cond and flags_q:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 → 0.
- Unlisted outputs are 0 in every state.

## Timing
- State and flags are registered; all outputs are combinational from state, inputs and flags_q.
- Reset: state=FETCH and flags_q=0000 asynchronously. While rst_n=0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. First fetch happens on the first edge after release.
- Reset asserted mid-instruction aborts it; no further writes occur.
- Latency with mem_ready=1:
  - Data-processing: 4 cycles.
  - CMP: 3 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Op=11: 2 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- The flag update uses CondEx evaluated on the old flags, in the same cycle.

## Structure
- Package `arm_ctrl_pkg`:
  - state enum;
  - ALUControl, ImmSrc and ResultSrc constants;
  - condition-code constants.
- Sub-module `cond_unit`: flag register, CondEx logic and the flag-write gating.
- Top contains the FSM and output decode.

## Test plan
- Reset then ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000), mem_ready=1 → FETCH→DECODE→EXEC_R→ALUWB, RegWrite=1 in cycle 4, ALUControl=000.
- SUBS with ALUFlags=0110 (Funct=000101) → flags_q=0110 after EXEC_R. Then ADDEQ → RegWrite=1; ADDNE → RegWrite=0, same 4-cycle length.
- LDR (Op=01, Funct=011001) with mem_ready low 2 cycles in MEMRD → 7 total cycles, ResultSrc=01 and RegWrite=1 in MEMWB.
- STR (Funct=011000) → MemWrite=1 and RegSrc=10 in MEMWR for every stall cycle, RegWrite never 1.
- B with Cond=0000 and Z=0 → 3 cycles, PCWrite=0 in BRANCH. Same with Z=1 → PCWrite=1, ImmSrc=10.
- rst_n low during MEMWR → MemWrite drops at once, state=FETCH, flags_q=0000.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared types and encodings for the multicycle ARM-subset controller
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam logic [3:0] CMD_CMP = 4'b1010;

    // Data-processing cmd field (Funct[4:1]) to ALU operation; CMP is a SUB
    function automatic logic [2:0] decode_alu(input logic [3:0] cmd);
        case (cmd)
            4'b0010: decode_alu = ALU_SUB;
            CMD_CMP: decode_alu = ALU_SUB;
            4'b0000: decode_alu = ALU_AND;
            4'b1100: decode_alu = ALU_ORR;
            4'b1101: decode_alu = ALU_MOV;
            default: decode_alu = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flag register, condition evaluation and gated flag writes
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_write_nz,
    input  logic       flag_write_cv,
    output logic [3:0] flags_q,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Gating uses cond_ex from the old flags, so a failed condition leaves flags intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            if (flag_write_nz && cond_ex) begin
                flags_q[3:2] <= alu_flags[3:2];
            end
            if (flag_write_cv && cond_ex) begin
                flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FSM and control decode for the multicycle ARM-subset datapath
module multicycle_controller
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [1:0] RegSrc,
    output logic [3:0] flags_q
);

    state_t     state, next_state;
    logic       cond_ex;
    logic       flag_write_nz, flag_write_cv;
    logic       pc_write, ir_write, reg_write, mem_write;
    logic [2:0] alu_dp;
    logic       is_cmp;

    assign alu_dp = decode_alu(Funct[4:1]);
    assign is_cmp = (Funct[4:1] == CMD_CMP);

    cond_unit u_cond_unit (
        .clk           (clk),
        .rst_n         (rst_n),
        .cond          (Cond),
        .alu_flags     (ALUFlags),
        .flag_write_nz (flag_write_nz),
        .flag_write_cv (flag_write_cv),
        .flags_q       (flags_q),
        .cond_ex       (cond_ex)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        ImmSrc        = IMM_8;
        RegSrc        = 2'b00;
        flag_write_nz = 1'b0;
        flag_write_cv = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = RES_ALU;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = Funct[5] ? S_EXEC_I : S_EXEC_R;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = IMM_12;
                next_state = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                reg_write  = cond_ex;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe is held for every stalled cycle until memory accepts it
                AdrSrc    = 1'b1;
                RegSrc    = 2'b10;
                mem_write = cond_ex;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                ALUSrcB       = (state == S_EXEC_I) ? 2'b01 : 2'b00;
                ImmSrc        = IMM_8;
                ALUControl    = alu_dp;
                flag_write_nz = Funct[0];
                flag_write_cv = Funct[0] && (alu_dp == ALU_ADD || alu_dp == ALU_SUB);
                next_state    = is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                reg_write  = cond_ex;
                pc_write   = cond_ex && (Rd == 4'd15);
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                RegSrc     = 2'b01;
                ALUSrcB    = 2'b01;
                ImmSrc     = IMM_24;
                ResultSrc  = RES_ALU;
                pc_write   = cond_ex;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Architectural writes are suppressed for as long as reset is held
    assign PCWrite  = pc_write  & rst_n;
    assign IRWrite  = ir_write  & rst_n;
    assign RegWrite = reg_write & rst_n;
    assign MemWrite = mem_write & rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] flags_q;

    int compared = 0;
    int mismatched = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .RegSrc     (RegSrc),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,RegSrc}
    logic [16:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, ImmSrc, RegWrite, RegSrc};

    localparam logic [16:0] F_GO    = 17'b1_0_0_1_10_1_10_000_00_0_00;
    localparam logic [16:0] F_STL   = 17'b0_0_0_0_10_1_10_000_00_0_00;
    localparam logic [16:0] DEC     = 17'b0_0_0_0_00_1_10_000_00_0_00;
    localparam logic [16:0] EXR_ADD = 17'b0_0_0_0_00_0_00_000_00_0_00;
    localparam logic [16:0] EXR_SUB = 17'b0_0_0_0_00_0_00_001_00_0_00;
    localparam logic [16:0] EXR_AND = 17'b0_0_0_0_00_0_00_010_00_0_00;
    localparam logic [16:0] EXI_MOV = 17'b0_0_0_0_00_0_01_100_00_0_00;
    localparam logic [16:0] WB1     = 17'b0_0_0_0_00_0_00_000_00_1_00;
    localparam logic [16:0] WB0     = 17'b0_0_0_0_00_0_00_000_00_0_00;
    localparam logic [16:0] WB_PC   = 17'b1_0_0_0_00_0_00_000_00_1_00;
    localparam logic [16:0] MADR    = 17'b0_0_0_0_00_0_01_000_01_0_00;
    localparam logic [16:0] MRD     = 17'b0_1_0_0_00_0_00_000_00_0_00;
    localparam logic [16:0] MWB     = 17'b0_0_0_0_01_0_00_000_00_1_00;
    localparam logic [16:0] MWR     = 17'b0_1_1_0_00_0_00_000_00_0_10;
    localparam logic [16:0] BR_T    = 17'b1_0_0_0_10_0_01_000_10_0_01;
    localparam logic [16:0] BR_N    = 17'b0_0_0_0_10_0_01_000_10_0_01;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [3:0]  fl;
        logic        mr;
        logic [16:0] exp;
        logic [3:0]  fexp;
    } row_t;

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; Cond = 4'hE; Op = 2'b00;
        Funct = 6'b001000; Rd = 4'd1; ALUFlags = 4'b1111;
        @(negedge clk);
        #1;
        compared++;
        if (obs !== F_STL) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want %b", obs, F_STL);
        end
        compared++;
        if (flags_q !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 0000", flags_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_data_processing();
        row_t t [13];
        t[0]  = '{4'hE, 2'b00, 6'b001000, 4'd1,  4'b1111, 1'b0, F_STL,   4'b0000};
        t[1]  = '{4'hE, 2'b00, 6'b001000, 4'd1,  4'b1111, 1'b1, F_GO,    4'b0000};
        t[2]  = '{4'hE, 2'b00, 6'b001000, 4'd1,  4'b1111, 1'b1, DEC,     4'b0000};
        t[3]  = '{4'hE, 2'b00, 6'b001000, 4'd1,  4'b1111, 1'b1, EXR_ADD, 4'b0000};
        t[4]  = '{4'hE, 2'b00, 6'b001000, 4'd1,  4'b1111, 1'b1, WB1,     4'b0000};
        t[5]  = '{4'hE, 2'b00, 6'b001000, 4'd15, 4'b1111, 1'b1, F_GO,    4'b0000};
        t[6]  = '{4'hE, 2'b00, 6'b001000, 4'd15, 4'b1111, 1'b1, DEC,     4'b0000};
        t[7]  = '{4'hE, 2'b00, 6'b001000, 4'd15, 4'b1111, 1'b1, EXR_ADD, 4'b0000};
        t[8]  = '{4'hE, 2'b00, 6'b001000, 4'd15, 4'b1111, 1'b1, WB_PC,   4'b0000};
        t[9]  = '{4'hE, 2'b00, 6'b111010, 4'd2,  4'b1111, 1'b1, F_GO,    4'b0000};
        t[10] = '{4'hE, 2'b00, 6'b111010, 4'd2,  4'b1111, 1'b1, DEC,     4'b0000};
        t[11] = '{4'hE, 2'b00, 6'b111010, 4'd2,  4'b1111, 1'b1, EXI_MOV, 4'b0000};
        t[12] = '{4'hE, 2'b00, 6'b111010, 4'd2,  4'b1111, 1'b1, WB1,     4'b0000};
        for (int i = 0; i < 13; i++) begin
            Cond = t[i].cond; Op = t[i].op; Funct = t[i].funct; Rd = t[i].rd;
            ALUFlags = t[i].fl; mem_ready = t[i].mr;
            #1;
            compared++;
            if (obs !== t[i].exp) begin
                mismatched++;
                $display("FAIL dp_ctrl c%0d: got %b want %b", i, obs, t[i].exp);
            end
            compared++;
            if (flags_q !== t[i].fexp) begin
                mismatched++;
                $display("FAIL dp_flags c%0d: got %b want %b", i, flags_q, t[i].fexp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flags();
        row_t t [25];
        // SUBS, AL, ALU flags 0110
        t[0]  = '{4'hE, 2'b00, 6'b000101, 4'd1, 4'b0110, 1'b1, F_GO,    4'b0000};
        t[1]  = '{4'hE, 2'b00, 6'b000101, 4'd1, 4'b0110, 1'b1, DEC,     4'b0000};
        t[2]  = '{4'hE, 2'b00, 6'b000101, 4'd1, 4'b0110, 1'b1, EXR_SUB, 4'b0000};
        t[3]  = '{4'hE, 2'b00, 6'b000101, 4'd1, 4'b0110, 1'b1, WB1,     4'b0110};
        // ADDEQ with Z=1
        t[4]  = '{4'h0, 2'b00, 6'b001000, 4'd1, 4'b1001, 1'b1, F_GO,    4'b0110};
        t[5]  = '{4'h0, 2'b00, 6'b001000, 4'd1, 4'b1001, 1'b1, DEC,     4'b0110};
        t[6]  = '{4'h0, 2'b00, 6'b001000, 4'd1, 4'b1001, 1'b1, EXR_ADD, 4'b0110};
        t[7]  = '{4'h0, 2'b00, 6'b001000, 4'd1, 4'b1001, 1'b1, WB1,     4'b0110};
        // ADDNE with Z=1: still four cycles, no write
        t[8]  = '{4'h1, 2'b00, 6'b001000, 4'd1, 4'b1001, 1'b1, F_GO,    4'b0110};
        t[9]  = '{4'h1, 2'b00, 6'b001000, 4'd1, 4'b1001, 1'b1, DEC,     4'b0110};
        t[10] = '{4'h1, 2'b00, 6'b001000, 4'd1, 4'b1001, 1'b1, EXR_ADD, 4'b0110};
        t[11] = '{4'h1, 2'b00, 6'b001000, 4'd1, 4'b1001, 1'b1, WB0,     4'b0110};
        // ADDSNE: failed condition must not touch the flags
        t[12] = '{4'h1, 2'b00, 6'b001001, 4'd1, 4'b1001, 1'b1, F_GO,    4'b0110};
        t[13] = '{4'h1, 2'b00, 6'b001001, 4'd1, 4'b1001, 1'b1, DEC,     4'b0110};
        t[14] = '{4'h1, 2'b00, 6'b001001, 4'd1, 4'b1001, 1'b1, EXR_ADD, 4'b0110};
        t[15] = '{4'h1, 2'b00, 6'b001001, 4'd1, 4'b1001, 1'b1, WB0,     4'b0110};
        // ANDS: N,Z load from 1011, C,V keep 1,0
        t[16] = '{4'hE, 2'b00, 6'b000001, 4'd1, 4'b1011, 1'b1, F_GO,    4'b0110};
        t[17] = '{4'hE, 2'b00, 6'b000001, 4'd1, 4'b1011, 1'b1, DEC,     4'b0110};
        t[18] = '{4'hE, 2'b00, 6'b000001, 4'd1, 4'b1011, 1'b1, EXR_AND, 4'b0110};
        t[19] = '{4'hE, 2'b00, 6'b000001, 4'd1, 4'b1011, 1'b1, WB1,     4'b1010};
        // CMP: three cycles, all four flags load
        t[20] = '{4'hE, 2'b00, 6'b010101, 4'd1, 4'b0011, 1'b1, F_GO,    4'b1010};
        t[21] = '{4'hE, 2'b00, 6'b010101, 4'd1, 4'b0011, 1'b1, DEC,     4'b1010};
        t[22] = '{4'hE, 2'b00, 6'b010101, 4'd1, 4'b0011, 1'b1, EXR_SUB, 4'b1010};
        // Op=11 no-op: two cycles
        t[23] = '{4'hE, 2'b11, 6'b000000, 4'd1, 4'b0000, 1'b1, F_GO,    4'b0011};
        t[24] = '{4'hE, 2'b11, 6'b000000, 4'd1, 4'b0000, 1'b1, DEC,     4'b0011};
        for (int i = 0; i < 25; i++) begin
            Cond = t[i].cond; Op = t[i].op; Funct = t[i].funct; Rd = t[i].rd;
            ALUFlags = t[i].fl; mem_ready = t[i].mr;
            #1;
            compared++;
            if (obs !== t[i].exp) begin
                mismatched++;
                $display("FAIL flags_ctrl c%0d: got %b want %b", i, obs, t[i].exp);
            end
            compared++;
            if (flags_q !== t[i].fexp) begin
                mismatched++;
                $display("FAIL flags_q c%0d: got %b want %b", i, flags_q, t[i].fexp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_store();
        row_t t [13];
        t[0]  = '{4'hE, 2'b01, 6'b011001, 4'd3, 4'b1111, 1'b1, F_GO, 4'b0011};
        t[1]  = '{4'hE, 2'b01, 6'b011001, 4'd3, 4'b1111, 1'b1, DEC,  4'b0011};
        t[2]  = '{4'hE, 2'b01, 6'b011001, 4'd3, 4'b1111, 1'b1, MADR, 4'b0011};
        t[3]  = '{4'hE, 2'b01, 6'b011001, 4'd3, 4'b1111, 1'b0, MRD,  4'b0011};
        t[4]  = '{4'hE, 2'b01, 6'b011001, 4'd3, 4'b1111, 1'b0, MRD,  4'b0011};
        t[5]  = '{4'hE, 2'b01, 6'b011001, 4'd3, 4'b1111, 1'b1, MRD,  4'b0011};
        t[6]  = '{4'hE, 2'b01, 6'b011001, 4'd3, 4'b1111, 1'b1, MWB,  4'b0011};
        t[7]  = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b1, F_GO, 4'b0011};
        t[8]  = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b1, DEC,  4'b0011};
        t[9]  = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b1, MADR, 4'b0011};
        t[10] = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b0, MWR,  4'b0011};
        t[11] = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b0, MWR,  4'b0011};
        t[12] = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b1, MWR,  4'b0011};
        for (int i = 0; i < 13; i++) begin
            Cond = t[i].cond; Op = t[i].op; Funct = t[i].funct; Rd = t[i].rd;
            ALUFlags = t[i].fl; mem_ready = t[i].mr;
            #1;
            compared++;
            if (obs !== t[i].exp) begin
                mismatched++;
                $display("FAIL ldst_ctrl c%0d: got %b want %b", i, obs, t[i].exp);
            end
            compared++;
            if (flags_q !== t[i].fexp) begin
                mismatched++;
                $display("FAIL ldst_flags c%0d: got %b want %b", i, flags_q, t[i].fexp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        row_t t [9];
        // BEQ with Z=0 (flags 0011): not taken
        t[0] = '{4'h0, 2'b10, 6'b101010, 4'd0, 4'b0100, 1'b1, F_GO,    4'b0011};
        t[1] = '{4'h0, 2'b10, 6'b101010, 4'd0, 4'b0100, 1'b1, DEC,     4'b0011};
        t[2] = '{4'h0, 2'b10, 6'b101010, 4'd0, 4'b0100, 1'b1, BR_N,    4'b0011};
        // CMP setting Z=1
        t[3] = '{4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 1'b1, F_GO,    4'b0011};
        t[4] = '{4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 1'b1, DEC,     4'b0011};
        t[5] = '{4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 1'b1, EXR_SUB, 4'b0011};
        // BEQ with Z=1: taken
        t[6] = '{4'h0, 2'b10, 6'b101010, 4'd0, 4'b0000, 1'b1, F_GO,    4'b0100};
        t[7] = '{4'h0, 2'b10, 6'b101010, 4'd0, 4'b0000, 1'b1, DEC,     4'b0100};
        t[8] = '{4'h0, 2'b10, 6'b101010, 4'd0, 4'b0000, 1'b1, BR_T,    4'b0100};
        for (int i = 0; i < 9; i++) begin
            Cond = t[i].cond; Op = t[i].op; Funct = t[i].funct; Rd = t[i].rd;
            ALUFlags = t[i].fl; mem_ready = t[i].mr;
            #1;
            compared++;
            if (obs !== t[i].exp) begin
                mismatched++;
                $display("FAIL br_ctrl c%0d: got %b want %b", i, obs, t[i].exp);
            end
            compared++;
            if (flags_q !== t[i].fexp) begin
                mismatched++;
                $display("FAIL br_flags c%0d: got %b want %b", i, flags_q, t[i].fexp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        row_t t [5];
        t[0] = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b1, F_GO, 4'b0100};
        t[1] = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b1, DEC,  4'b0100};
        t[2] = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b1, MADR, 4'b0100};
        t[3] = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b0, MWR,  4'b0100};
        t[4] = '{4'hE, 2'b01, 6'b011000, 4'd3, 4'b1111, 1'b0, MWR,  4'b0100};
        for (int i = 0; i < 5; i++) begin
            Cond = t[i].cond; Op = t[i].op; Funct = t[i].funct; Rd = t[i].rd;
            ALUFlags = t[i].fl; mem_ready = t[i].mr;
            #1;
            compared++;
            if (obs !== t[i].exp) begin
                mismatched++;
                $display("FAIL abort_ctrl c%0d: got %b want %b", i, obs, t[i].exp);
            end
            @(negedge clk);
        end
        // Still in MEMWR with memory stalled; reset must take effect immediately
        rst_n = 1'b0;
        #1;
        compared++;
        if (MemWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_memwrite: got %b want 0", MemWrite);
        end
        compared++;
        if (obs !== F_STL) begin
            mismatched++;
            $display("FAIL abort_state: got %b want %b", obs, F_STL);
        end
        compared++;
        if (flags_q !== 4'b0000) begin
            mismatched++;
            $display("FAIL abort_flags: got %b want 0000", flags_q);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compared++;
        if (obs !== F_GO) begin
            mismatched++;
            $display("FAIL abort_refetch: got %b want %b", obs, F_GO);
        end
        @(negedge clk);
        #1;
        compared++;
        if (obs !== DEC) begin
            mismatched++;
            $display("FAIL abort_decode: got %b want %b", obs, DEC);
        end
    endtask

    initial begin
        test_reset();
        test_data_processing();
        test_flags();
        test_load_store();
        test_branch();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
